spi_slave: RTL and testbench

SPI slave endpoint for the on-chip SPI link, sitting directly downstream of `spi_master` on the `sclk`/`mosi`/`miso` wires. It oversamples the external SPI pins in the system clock domain and supports all four CPOL/CPHA modes. Each received 8-bit byte is delivered as a one-cycle strobe. Each outgoing byte comes from a one-entry transmit holding register filled by a valid/ready handshake. It targets the master's 50-clk half-period `sclk`, so pin oversampling has ample margin.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync.sv | 31 +++
 rtl/spi_slave.sv | 145 ++++++++++++++
 tb/tb_spi_slave.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the on-chip SPI link (master and slave).
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int SPI_BITS  = 8;
    localparam int SCLK_HALF = 50;
    localparam int CNT_W     = $clog2(SPI_BITS);

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for an asynchronous pin, with registered-previous edge detect.
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [N-1:0] r_sync;
    logic         r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= {N{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[N-2:0], d};
            r_prev <= r_sync[N-1];
        end
    end

    assign q    = r_sync[N-1];
    assign rise = r_sync[N-1] & ~r_prev;
    assign fall = ~r_sync[N-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled pins, all four CPOL/CPHA modes, one-entry TX holding register.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                sclk,
    input  logic                mosi,
    input  logic                ss_n,
    output logic                miso,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy,
    output logic                tx_underrun,
    output logic                frame_err,
    output state_t              dbg_state
);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_mosi_q, w_mosi_unused_rise, w_mosi_unused_fall;
    logic w_ss_q, w_ss_unused_rise, w_ss_unused_fall;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d(sclk),
        .q(w_sclk_q), .rise(w_sclk_rise), .fall(w_sclk_fall)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(mosi),
        .q(w_mosi_q), .rise(w_mosi_unused_rise), .fall(w_mosi_unused_fall)
    );
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .d(ss_n),
        .q(w_ss_q), .rise(w_ss_unused_rise), .fall(w_ss_unused_fall)
    );

    logic w_sclk_unused;
    assign w_sclk_unused = w_sclk_q;

    state_t              r_state, w_next_state;
    logic                r_cpol, r_cpha;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [SPI_BITS-1:0] r_rx_shift, r_rx_data, r_tx_shift, r_hold;
    logic                r_hold_full, r_rx_valid, r_tx_underrun, r_frame_err;

    logic w_lead, w_trail, w_run, w_start, w_stop, w_sample, w_wrap, w_shift, w_load, w_write;
    logic [SPI_BITS-1:0] w_rx_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_ss_q) w_next_state = ACTIVE;
            ACTIVE:  if (w_ss_q)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // An ss_n rise (w_stop) masks any sclk edge detected in the same cycle.
    always_comb begin
        w_lead   = r_cpol ? w_sclk_fall : w_sclk_rise;
        w_trail  = r_cpol ? w_sclk_rise : w_sclk_fall;
        w_start  = (r_state == IDLE) && !w_ss_q;
        w_stop   = (r_state == ACTIVE) && w_ss_q;
        w_run    = (r_state == ACTIVE) && !w_ss_q;
        w_sample = w_run && (r_cpha ? w_trail : w_lead);
        w_wrap   = w_sample && (r_bit_cnt == CNT_W'(SPI_BITS - 1));
        w_shift  = w_run && (r_bit_cnt != '0) && (r_cpha ? w_lead : w_trail);
        w_load   = w_start || w_wrap;
    end

    assign w_rx_next = {r_rx_shift[SPI_BITS-2:0], w_mosi_q};
    assign w_write   = tx_valid && !r_hold_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpol        <= 1'b0;
            r_cpha        <= 1'b0;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_tx_shift    <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
            if (w_start) begin
                r_cpol    <= cpol;
                r_cpha    <= cpha;
                r_bit_cnt <= '0;
            end
            if (w_stop) begin
                r_bit_cnt   <= '0;
                r_frame_err <= (r_bit_cnt != '0);
            end else if (w_sample) begin
                r_rx_shift <= w_rx_next;
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                if (w_wrap) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end
            end
            if (w_stop) begin
                r_tx_shift <= '0;
            end else if (w_load) begin
                r_tx_shift    <= r_hold_full ? r_hold : '0;
                r_tx_underrun <= !r_hold_full;
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[SPI_BITS-2:0], 1'b0};
            end
            // A write can only land while empty, so it never collides with a consuming load.
            if (w_write) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign miso        = (r_state == ACTIVE) ? r_tx_shift[SPI_BITS-1] : 1'b0;
    assign busy        = (r_state == ACTIVE);
    assign tx_ready    = !r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign frame_err   = r_frame_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives the pins, a scoreboard checks bytes.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int H = SCLK_HALF;

    logic       clk = 1'b0;
    logic       reset_n, cpol, cpha, sclk, mosi, ss_n, tx_valid;
    logic [7:0] tx_data;
    logic       miso, tx_ready, rx_valid, busy, tx_underrun, frame_err;
    logic [7:0] rx_data;
    state_t     dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int rx_cnt = 0;
    int ur_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun), .frame_err(frame_err), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] d);
        int k = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("wr_accept", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("wr_ready_low", tx_ready, 1'b0);
    endtask

    // Behavioural master: sends mo[nbits-1:0] MSB first, returns the bits read from miso.
    task automatic spi_bits(input logic m_cpol, input logic m_cpha, input int nbits,
                            input logic [15:0] mo, output logic [15:0] mi);
        mi = '0;
        @(negedge clk);
        cpol = m_cpol;
        cpha = m_cpha;
        sclk = m_cpol;
        wait_clks(10);
        ss_n = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!m_cpha) begin
                mosi = mo[i];
                wait_clks(H);
                sclk = ~m_cpol;
                mi = {mi[14:0], miso};
                wait_clks(H);
                sclk = m_cpol;
            end else begin
                wait_clks(H);
                sclk = ~m_cpol;
                mosi = mo[i];
                wait_clks(H);
                sclk = m_cpol;
                mi = {mi[14:0], miso};
            end
        end
        wait_clks(H);
        ss_n = 1'b1;
        mosi = 1'b0;
        wait_clks(10);
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            check("rx_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("rx_byte", rx_data, exp_q.pop_front());
        end
        if (tx_underrun) ur_cnt++;
        if (frame_err)   fe_cnt++;
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: observed no finish expected finish within 80000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] mi;
        int rx0, ur0, fe0;

        reset_n = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; mosi = 1'b0;
        ss_n = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        wait_clks(5);
        check("rst_miso", miso, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {rx_valid, tx_underrun, frame_err}, 3'b000);
        reset_n = 1'b1;
        wait_clks(5);
        check("idle_state", dbg_state, IDLE);

        // Mode 0 loopback
        write_tx(8'hA5);
        exp_q.push_back(8'h3C);
        rx0 = rx_cnt;
        spi_bits(1'b0, 1'b0, 8, 16'h003C, mi);
        check("m0_master_rx", mi[7:0], 8'hA5);
        check("m0_rx_data", rx_data, 8'h3C);
        check("m0_rx_count", rx_cnt - rx0, 1);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            write_tx(8'h81);
            exp_q.push_back(8'h7E);
            rx0 = rx_cnt;
            spi_bits(logic'(m >> 1), logic'(m & 1), 8, 16'h007E, mi);
            check("mode_master_rx", mi[7:0], 8'h81);
            check("mode_rx_data", rx_data, 8'h7E);
            check("mode_rx_count", rx_cnt - rx0, 1);
        end

        // Two-byte frame with a refill during byte 1
        write_tx(8'h11);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        rx0 = rx_cnt;
        fork
            spi_bits(1'b0, 1'b0, 16, 16'hA55A, mi);
            begin
                wait_clks(300);
                check("two_busy", busy, 1'b1);
                check("two_state", dbg_state, ACTIVE);
                check("two_ready_after_load", tx_ready, 1'b1);
                write_tx(8'h22);
            end
        join
        check("two_master_rx", mi, 16'h1122);
        check("two_rx_count", rx_cnt - rx0, 2);
        check("two_ready_end", tx_ready, 1'b1);
        check("two_idle_miso", miso, 1'b0);

        // Frame starts with empty holding register; refilled before the byte-end load
        ur0 = ur_cnt;
        exp_q.push_back(8'h96);
        fork
            spi_bits(1'b0, 1'b0, 8, 16'h0096, mi);
            begin
                wait_clks(300);
                write_tx(8'h5B);
            end
        join
        check("ur_count", ur_cnt - ur0, 1);
        check("ur_master_rx", mi[7:0], 8'h00);
        check("ur_rx_data", rx_data, 8'h96);

        // Short frame then a good one
        rx0 = rx_cnt;
        fe0 = fe_cnt;
        spi_bits(1'b0, 1'b0, 5, 16'h0015, mi);
        check("fe_count", fe_cnt - fe0, 1);
        check("fe_no_rx", rx_cnt - rx0, 0);
        exp_q.push_back(8'hC3);
        spi_bits(1'b0, 1'b0, 8, 16'h00C3, mi);
        check("fe_next_rx", rx_data, 8'hC3);
        check("fe_next_count", rx_cnt - rx0, 1);
        check("fe_no_more_err", fe_cnt - fe0, 1);

        // Reset mid-byte
        write_tx(8'hF0);
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
        ss_n = 1'b0;
        wait_clks(20);
        check("rst_mid_busy", busy, 1'b1);
        check("rst_mid_miso", miso, 1'b1);
        mosi = 1'b1;
        wait_clks(H);
        sclk = 1'b1;
        wait_clks(20);
        rx0 = rx_cnt; ur0 = ur_cnt; fe0 = fe_cnt;
        reset_n = 1'b0;
        #1;
        check("rst_mid_miso0", miso, 1'b0);
        check("rst_mid_rx_data", rx_data, 8'h00);
        check("rst_mid_tx_ready", tx_ready, 1'b1);
        check("rst_mid_busy0", busy, 1'b0);
        check("rst_mid_strobes", {rx_valid, tx_underrun, frame_err}, 3'b000);
        wait_clks(2);
        ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(100);
        check("rst_post_strobes", (rx_cnt - rx0) + (ur_cnt - ur0) + (fe_cnt - fe0), 0);
        check("rst_post_state", dbg_state, IDLE);

        check("rx_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
